// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer and its return-address stack.
package pc_seq_pkg;

    // Default return-address stack depth and the pointer width it implies.
    localparam int DEFAULT_RAS_DEPTH = 4;
    localparam int RAS_PTR_W         = $clog2(DEFAULT_RAS_DEPTH);

    // Source of the next PC, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_CALL,
        SEL_RET,
        SEL_HOLD
    } next_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// A push onto a full stack overwrites the oldest entry and sets a sticky overflow flag.
// A pop of an empty stack is ignored.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_prev;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign top_prev = top - 1'b1;
    assign top_data = mem[top_prev];
    assign do_pop   = pop && !empty;
    assign do_push  = push && !pop;

    // Pointer, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            top      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (do_pop) begin
            top   <= top_prev;
            count <= count - 1'b1;
        end else if (do_push) begin
            top <= top + 1'b1;
            if (count != FULL_COUNT) begin
                count <= count + 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage has no reset; a push writes at the current top slot.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[top] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer.
// It holds the registered PC and selects the next PC from the sequential,
// branch, jump, call and return sources. Calls and returns use a return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                PC_STEP   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] simm,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_step,
    output logic [ADDR_W-1:0] pc_branch,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ret_underflow
);

    next_sel_e         sel;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push;
    logic              ras_pop;

    // Both sums are taken modulo 2^ADDR_W, so the PC wraps silently.
    assign pc_plus_step = pc + ADDR_W'(PC_STEP);
    assign pc_branch    = pc_plus_step + simm;

    // Resolve simultaneous control requests by fixed priority.
    always_comb begin
        sel = SEL_SEQ;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = SEL_RET;
        end else if (call) begin
            sel = SEL_CALL;
        end else if (jump) begin
            sel = SEL_JMP;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    assign ras_push = (sel == SEL_CALL);
    assign ras_pop  = (sel == SEL_RET) && !ras_empty;

    ras_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_step),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

    // Register the next PC and the one-cycle underflow pulse for an empty return.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            ret_underflow <= 1'b0;
        end else begin
            ret_underflow <= 1'b0;
            unique case (sel)
                SEL_HOLD: pc <= pc;
                SEL_RET: begin
                    if (ras_empty) begin
                        pc            <= pc_plus_step;
                        ret_underflow <= 1'b1;
                    end else begin
                        pc <= ras_top;
                    end
                end
                SEL_CALL: pc <= jump_target;
                SEL_JMP:  pc <= jump_target;
                SEL_BR:   pc <= pc_branch;
                default:  pc <= pc_plus_step;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// A behavioural model queues the expected state after each edge, and the queue is drained after the edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] simm = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic [31:0] pc_branch;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ret_underflow;

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        uf;
    } exp_t;

    exp_t        expQueue[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mPc = '0;
    logic [31:0] mRas [4];
    int          mCount = 0;
    int          mTop = 0;
    logic        mOvf = 1'b0;
    logic        mUf = 1'b0;

    pc_sequencer #(
        .ADDR_W    (32),
        .PC_STEP   (1),
        .RESET_PC  (32'd0),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .simm          (simm),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus_step  (pc_plus_step),
        .pc_branch     (pc_branch),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ret_underflow (ret_underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // Drive one cycle of controls, check the combinational sums, advance the model, and compare after the edge.
    task automatic applyStimulus(input logic rs, input logic st, input logic br, input logic jp,
                                 input logic cl, input logic rt, input logic [31:0] tgt,
                                 input logic [31:0] offs);
        exp_t e;
        logic [31:0] plus;
        @(negedge clk);
        reset = rs; stall = st; branch_taken = br; jump = jp; call = cl; ret = rt;
        jump_target = tgt; simm = offs;
        #1;
        plus = mPc + 32'd1;
        if (!rs) begin
            checkOutput("pc_plus_step", pc_plus_step, plus);
            checkOutput("pc_branch", pc_branch, plus + offs);
        end
        mUf = 1'b0;
        if (rs) begin
            mPc = '0; mCount = 0; mTop = 0; mOvf = 1'b0;
        end else if (st) begin
            mPc = mPc;
        end else if (rt) begin
            if (mCount == 0) begin
                mPc = plus; mUf = 1'b1;
            end else begin
                mTop = (mTop + 3) % 4; mPc = mRas[mTop]; mCount--;
            end
        end else if (cl) begin
            mRas[mTop] = plus; mTop = (mTop + 1) % 4;
            if (mCount < 4) mCount++; else mOvf = 1'b1;
            mPc = tgt;
        end else if (jp) begin
            mPc = tgt;
        end else if (br) begin
            mPc = plus + offs;
        end else begin
            mPc = plus;
        end
        e.pc = mPc; e.empty = (mCount == 0); e.full = (mCount == 4); e.ovf = mOvf; e.uf = mUf;
        expQueue.push_back(e);
        @(posedge clk);
        #1;
        e = expQueue.pop_front();
        checkOutput("pc", pc, e.pc);
        checkOutput("ras_empty", {31'd0, ras_empty}, {31'd0, e.empty});
        checkOutput("ras_full", {31'd0, ras_full}, {31'd0, e.full});
        checkOutput("ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
        checkOutput("ret_underflow", {31'd0, ret_underflow}, {31'd0, e.uf});
    endtask

    initial begin
        // Reset, then free-running sequential fetch.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Backward branch from pc 10 with offset -4 lands on 7.
        applyStimulus(0, 0, 0, 1, 0, 0, 32'd10, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);

        // Wrap from the top of the address space.
        applyStimulus(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Call at 5 into 100, run three cycles, return to 6.
        applyStimulus(0, 0, 0, 1, 0, 0, 32'd5, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'd100, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

        // Five nested calls overflow the four-entry stack, then unwind past empty.
        applyStimulus(0, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0, 32'(i * 10 + 10), 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Stall masks a call for two cycles; releasing it lets the call through once.
        applyStimulus(0, 0, 0, 1, 0, 0, 32'd40, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 32'd200, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 32'd200, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'd200, 0);
        applyStimulus(0, 0, 1, 0, 1, 1, 32'd300, 32'd7);

        // Reset together with a return discards a partly filled stack.
        applyStimulus(0, 0, 0, 0, 1, 0, 32'd50, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'd60, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
